fb_scaler: RTL and testbench

FB_SCALER -- requirements
Module: fb_scaler

---
 rtl/vid_pkg.sv | 24 ++
 rtl/pipe_delay.sv | 25 ++
 rtl/fb_scaler.sv | 124 ++++++++++++
 tb/tb_fb_scaler.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vid_pkg.sv
// rtl/vid_pkg.sv - shared video constants: scale encoding and default 800x600 timing
package vid_pkg;

  typedef enum logic [1:0] {
    SCALE_1X   = 2'd0,
    SCALE_2X   = 2'd1,
    SCALE_4X   = 2'd2,
    SCALE_RSVD = 2'd3
  } scale_e;

  localparam int H_ACTIVE_DEF = 800;
  localparam int V_ACTIVE_DEF = 600;
  localparam int CB_DEF       = 3;

  // Reserved encoding falls back to 2x.
  function automatic logic [1:0] scale_shift(input logic [1:0] sel);
    case (scale_e'(sel))
      SCALE_1X: return 2'd0;
      SCALE_4X: return 2'd2;
      default:  return 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/pipe_delay.sv
// rtl/pipe_delay.sv - fixed-depth register delay line with synchronous clear
module pipe_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/fb_scaler.sv
// rtl/fb_scaler.sv - integer upscaler mapping timing counters to image memory reads and pixels
module fb_scaler
  import vid_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int IMG_W    = 400,
  parameter int IMG_H    = 300,
  parameter int CB       = CB_DEF,
  parameter int ADDR_W   = 17,
  parameter int RD_LAT   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [10:0]       h_count,
  input  logic [9:0]        v_count,
  input  logic [1:0]        scale_sel,
  input  logic [3*CB-1:0]   border_rgb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  input  logic [3*CB-1:0]   mem_data,
  output logic [CB-1:0]     red,
  output logic [CB-1:0]     green,
  output logic [CB-1:0]     blue,
  output logic              pix_active
);

  localparam int PW = 2 + 3*CB;

  logic [1:0]        scale_q, scale_d;
  logic [ADDR_W-1:0] line_base_q, line_base_d;
  logic              synced_q, synced_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_en_q, mem_en_d;
  logic [3*CB-1:0]   rgb_q, rgb_d;
  logic              pix_active_q, pix_active_d;

  logic              h_act, v_act, active_s0, in_img_s0;
  logic              line_end, frame_end, row_step;
  logic [10:0]       col;
  logic [9:0]        row, row_mask;
  logic [PW-1:0]     dly_in, dly_out;
  logic              act_dl, in_img_dl;
  logic [3*CB-1:0]   border_dl;

  // Stage 0: classify the counter sample; the h=0,v=0 sample itself is already in sync.
  always_comb begin
    h_act     = h_count < 11'(H_ACTIVE);
    v_act     = v_count < 10'(V_ACTIVE);
    col       = h_count >> scale_q;
    row       = v_count >> scale_q;
    synced_d  = synced_q | (h_count == 11'd0 && v_count == 10'd0);
    active_s0 = synced_d & h_act & v_act;
    in_img_s0 = active_s0 && (col < 11'(IMG_W)) && (row < 10'(IMG_H));
  end

  // Row base advances by IMG_W once per 2^s lines; stops past the image so it never overflows.
  always_comb begin
    row_mask    = (10'd1 << scale_q) - 10'd1;
    line_end    = (h_count == 11'(H_ACTIVE)) && v_act;
    frame_end   = line_end && (v_count == 10'(V_ACTIVE-1));
    row_step    = (((v_count + 10'd1) & row_mask) == 10'd0) && (row < 10'(IMG_H));
    line_base_d = line_base_q;
    scale_d     = scale_q;
    if (frame_end) begin
      line_base_d = '0;
      scale_d     = scale_shift(scale_sel);
    end else if (line_end && synced_q && row_step) begin
      line_base_d = line_base_q + ADDR_W'(IMG_W);
    end
  end

  always_comb begin
    mem_en_d   = in_img_s0;
    mem_addr_d = in_img_s0 ? line_base_q + ADDR_W'(col) : mem_addr_q;
  end

  assign dly_in = {active_s0, in_img_s0, border_rgb};

  pipe_delay #(
    .WIDTH(PW),
    .DEPTH(RD_LAT + 1)
  ) u_align (
    .clk   (clk),
    .reset (reset),
    .din_i (dly_in),
    .dout_o(dly_out)
  );

  assign {act_dl, in_img_dl, border_dl} = dly_out;

  always_comb begin
    rgb_d        = '0;
    pix_active_d = act_dl;
    if (in_img_dl) rgb_d = mem_data;
    else if (act_dl) rgb_d = border_dl;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scale_q      <= SCALE_2X;
      line_base_q  <= '0;
      synced_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_en_q     <= 1'b0;
      rgb_q        <= '0;
      pix_active_q <= 1'b0;
    end else begin
      scale_q      <= scale_d;
      line_base_q  <= line_base_d;
      synced_q     <= synced_d;
      mem_addr_q   <= mem_addr_d;
      mem_en_q     <= mem_en_d;
      rgb_q        <= rgb_d;
      pix_active_q <= pix_active_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_en     = mem_en_q;
  assign {red, green, blue} = rgb_q;
  assign pix_active = pix_active_q;

endmodule

// File: tb/tb_fb_scaler.sv
// tb/tb_fb_scaler.sv - vector table plus scoreboard against a multiplying reference model
module tb_fb_scaler;

  localparam int H_ACTIVE = 800;
  localparam int V_ACTIVE = 600;
  localparam int IMG_W    = 400;
  localparam int IMG_H    = 300;
  localparam int CB       = 3;
  localparam int ADDR_W   = 17;
  localparam int RD_LAT   = 1;
  localparam int L        = RD_LAT + 2;
  localparam int NV       = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] h_count;
  logic [9:0]  v_count;
  logic [1:0]  scale_sel;
  logic [8:0]  border_rgb;
  logic [16:0] mem_addr;
  logic        mem_en;
  logic [8:0]  mem_data;
  logic [2:0]  red, green, blue;
  logic        pix_active;
  logic [8:0]  mem_pipe [RD_LAT];

  fb_scaler #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .IMG_W(IMG_W), .IMG_H(IMG_H),
    .CB(CB), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .reset(reset), .h_count(h_count), .v_count(v_count),
    .scale_sel(scale_sel), .border_rgb(border_rgb), .mem_addr(mem_addr),
    .mem_en(mem_en), .mem_data(mem_data), .red(red), .green(green),
    .blue(blue), .pix_active(pix_active)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] pat(input logic [16:0] a);
    return a[8:0] ^ a[16:8];
  endfunction

  function automatic int ref_shift(input logic [1:0] sel);
    if (sel == 2'd0) return 0;
    if (sel == 2'd2) return 2;
    return 1;
  endfunction

  // Image memory: content is a function of address, RD_LAT cycles of latency.
  always @(posedge clk) begin
    mem_pipe[0] <= mem_en ? pat(mem_addr) : 9'h0;
    for (int i = 1; i < RD_LAT; i++) mem_pipe[i] <= mem_pipe[i-1];
  end
  assign mem_data = mem_pipe[RD_LAT-1];

  typedef struct {
    logic       act;
    logic [8:0] rgb;
  } exp_t;

  typedef struct {
    int         scale;
    int         h;
    int         v;
    logic [8:0] border;
    logic       exp_en;
    logic       chk_addr;
    int         exp_addr;
    logic       exp_act;
    logic [8:0] exp_rgb;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[NV];
  int          errors = 0;
  int          checks = 0;
  logic        exp_en_prev = 1'b0;
  logic [16:0] exp_addr_prev = '0;
  logic        m_synced = 1'b0;
  int          m_shift = 1;
  logic        rst_drv = 1'b1;
  logic [1:0]  scale_drv = 2'd0;
  logic [8:0]  border_drv = 9'h0;
  logic        cap_en, cap_act, seen;
  logic [16:0] cap_addr;
  logic [8:0]  cap_rgb;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // One clock: sample outputs, score them, then drive the next counter sample.
  task automatic step(input int h, input int v);
    exp_t e;
    int   col, row;
    logic syn_now, act, inimg;
    @(negedge clk);
    cap_en   = mem_en;
    cap_addr = mem_addr;
    cap_rgb  = {red, green, blue};
    cap_act  = pix_active;
    seen     = seen | cap_en | cap_act;
    if (sb.size() == L) begin
      e = sb.pop_front();
      chk("sb_pix_active", 32'(cap_act), 32'(e.act));
      chk("sb_rgb", 32'(cap_rgb), 32'(e.rgb));
    end
    chk("sb_mem_en", 32'(cap_en), 32'(exp_en_prev));
    chk("sb_mem_addr", 32'(cap_addr), 32'(exp_addr_prev));
    reset      = rst_drv;
    h_count    = 11'(h);
    v_count    = 10'(v);
    scale_sel  = scale_drv;
    border_rgb = border_drv;
    if (rst_drv) begin
      for (int i = 0; i < sb.size(); i++) begin
        sb[i].act = 1'b0;
        sb[i].rgb = 9'h0;
      end
      e.act = 1'b0;
      e.rgb = 9'h0;
      sb.push_back(e);
      exp_en_prev   = 1'b0;
      exp_addr_prev = '0;
      m_synced      = 1'b0;
      m_shift       = 1;
    end else begin
      syn_now = m_synced || (h == 0 && v == 0);
      col     = h >> m_shift;
      row     = v >> m_shift;
      act     = syn_now && h < H_ACTIVE && v < V_ACTIVE;
      inimg   = act && col < IMG_W && row < IMG_H;
      e.act   = act;
      e.rgb   = inimg ? pat(17'(row*IMG_W + col)) : (act ? border_drv : 9'h0);
      sb.push_back(e);
      exp_en_prev = inimg;
      if (inimg) exp_addr_prev = 17'(row*IMG_W + col);
      m_synced = syn_now;
      if (h == H_ACTIVE && v == V_ACTIVE-1) m_shift = ref_shift(scale_drv);
    end
  endtask

  task automatic scan_lines(input int v0, input int v1);
    for (int v = v0; v <= v1; v++) begin
      border_drv = 9'($urandom);
      step(0, v);
      step(int'($urandom_range(0, 799)), v);
      step(H_ACTIVE, v);
    end
  endtask

  task automatic new_frame();
    step(H_ACTIVE, V_ACTIVE-1);
    step(1000, 620);
  endtask

  initial begin
    reset = 1'b1; h_count = 11'd1000; v_count = 10'd650;
    scale_sel = 2'd0; border_rgb = 9'h0;

    vecs[0] = '{1, 5,    7,   9'h1A5,        1'b1, 1'b1, 1202,   1'b1, pat(17'd1202)};
    vecs[1] = '{0, 400,  10,  9'b101010111,  1'b0, 1'b0, 0,      1'b1, 9'b101010111};
    vecs[2] = '{2, 799,  599, 9'h0F3,        1'b1, 1'b1, 59799,  1'b1, pat(17'd59799)};
    vecs[3] = '{2, 800,  599, 9'h1FF,        1'b0, 1'b0, 0,      1'b0, 9'h0};
    vecs[4] = '{3, 5,    7,   9'h055,        1'b1, 1'b1, 1202,   1'b1, pat(17'd1202)};
    vecs[5] = '{0, 399,  299, 9'h0AA,        1'b1, 1'b1, 119999, 1'b1, pat(17'd119999)};
    vecs[6] = '{0, 0,    300, 9'h123,        1'b0, 1'b0, 0,      1'b1, 9'h123};
    vecs[7] = '{1, 799,  599, 9'h0C3,        1'b1, 1'b1, 119999, 1'b1, pat(17'd119999)};
    vecs[8] = '{0, 1500, 50,  9'h1F0,        1'b0, 1'b0, 0,      1'b0, 9'h0};
    vecs[9] = '{0, 10,   700, 9'h00F,        1'b0, 1'b0, 0,      1'b0, 9'h0};

    // Reset state, pre-sync hold-off, and the 2x reset scale.
    rst_drv = 1'b1;
    border_drv = 9'h1FF;
    repeat (4) step(1000, 650);
    chk("reset_mem_en", 32'(cap_en), 32'd0);
    chk("reset_mem_addr", 32'(cap_addr), 32'd0);
    chk("reset_rgb", 32'(cap_rgb), 32'd0);
    chk("reset_pix_active", 32'(cap_act), 32'd0);
    rst_drv = 1'b0;
    step(5, 3);
    step(1000, 3);
    chk("presync_mem_en", 32'(cap_en), 32'd0);
    repeat (L-1) step(1000, 3);
    chk("presync_pix_active", 32'(cap_act), 32'd0);
    step(0, 0); step(H_ACTIVE, 0); step(0, 1); step(H_ACTIVE, 1);
    step(6, 2);
    step(1000, 2);
    chk("reset_scale_2x_addr", 32'(cap_addr), 32'd403);

    for (int i = 0; i < NV; i++) begin
      scale_drv = 2'(vecs[i].scale);
      new_frame();
      scan_lines(0, vecs[i].v - 1);
      border_drv = vecs[i].border;
      step(vecs[i].h, vecs[i].v);
      step(1000, vecs[i].v);
      chk($sformatf("vec%0d_mem_en", i), 32'(cap_en), 32'(vecs[i].exp_en));
      if (vecs[i].chk_addr) chk($sformatf("vec%0d_mem_addr", i), 32'(cap_addr), 32'(vecs[i].exp_addr));
      repeat (L-1) step(1000, vecs[i].v);
      chk($sformatf("vec%0d_pix_active", i), 32'(cap_act), 32'(vecs[i].exp_act));
      chk($sformatf("vec%0d_rgb", i), 32'(cap_rgb), 32'(vecs[i].exp_rgb));
    end

    // Scale change mid-frame only takes effect from the next frame.
    scale_drv = 2'd1;
    new_frame();
    scan_lines(0, 299);
    scale_drv = 2'd0;
    scan_lines(300, 399);
    step(10, 400);
    step(1000, 400);
    chk("midframe_stays_2x_addr", 32'(cap_addr), 32'd80005);
    step(H_ACTIVE, 400);
    scan_lines(401, 599);
    step(1000, 620);
    step(0, 0); step(H_ACTIVE, 0);
    step(0, 1);
    step(1000, 1);
    chk("next_frame_1x_mem_en", 32'(cap_en), 32'd1);
    chk("next_frame_1x_addr", 32'(cap_addr), 32'd400);

    // Mid-frame reset: silent until the next frame origin, then normal latency.
    new_frame();
    scan_lines(0, 99);
    rst_drv = 1'b1;
    step(5, 100);
    rst_drv = 1'b0;
    seen = 1'b0;
    scan_lines(100, 599);
    step(1000, 620);
    chk("reset_holdoff_quiet", 32'(seen), 32'd0);
    step(0, 0);
    step(1000, 0);
    chk("resync_mem_en", 32'(cap_en), 32'd1);
    chk("resync_mem_addr", 32'(cap_addr), 32'd0);
    repeat (L-1) step(1000, 0);
    chk("resync_pix_active", 32'(cap_act), 32'd1);
    repeat (L) step(1000, 620);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
